// File: rtl/tq_pkg.sv
// Shared constants for the dequant + 4x4 inverse transform pipeline:
// LevelScale table, coefficient position classes and output rounding.
package tq_pkg;

    typedef enum logic [1:0] {
        CLS_A = 2'd0,   // both row and column even
        CLS_B = 2'd1,   // both row and column odd
        CLS_C = 2'd2    // mixed parity
    } pos_cls_e;

    localparam int RND_ADD   = 32;
    localparam int RND_SHIFT = 6;
    localparam logic [5:0] QP_MAX = 6'd51;

    // Class of element k = 4*row + col in the 4x4 block
    function automatic pos_cls_e pos_class(input logic [3:0] k);
        logic r_odd;
        logic c_odd;
        r_odd = k[2];
        c_odd = k[0];
        if (!r_odd && !c_odd)    return CLS_A;
        else if (r_odd && c_odd) return CLS_B;
        else                     return CLS_C;
    endfunction

    // LevelScale V[qp%6][cls]
    function automatic logic [4:0] level_scale(input logic [2:0] qmod, input pos_cls_e cls);
        logic [4:0] va;
        logic [4:0] vb;
        logic [4:0] vc;
        case (qmod)
            3'd0:    begin va = 5'd10; vb = 5'd16; vc = 5'd13; end
            3'd1:    begin va = 5'd11; vb = 5'd18; vc = 5'd14; end
            3'd2:    begin va = 5'd13; vb = 5'd20; vc = 5'd16; end
            3'd3:    begin va = 5'd14; vb = 5'd23; vc = 5'd18; end
            3'd4:    begin va = 5'd16; vb = 5'd25; vc = 5'd20; end
            default: begin va = 5'd18; vb = 5'd29; vc = 5'd23; end
        endcase
        case (cls)
            CLS_A:   return va;
            CLS_B:   return vb;
            default: return vc;
        endcase
    endfunction

endpackage

// File: rtl/tq_itrans_1d.sv
// 4-point H.264 inverse integer butterfly. Inputs are sign-extended to the
// output width first so no intermediate result can wrap.
module tq_itrans_1d #(
    parameter int IW = 16,
    parameter int OW = 19
) (
    input  logic signed [IW-1:0] i_x [4],
    output logic signed [OW-1:0] o_y [4]
);
    logic signed [OW-1:0] w_x0, w_x1, w_x2, w_x3;
    logic signed [OW-1:0] w_e, w_f, w_g, w_h;

    assign w_x0 = OW'(i_x[0]);
    assign w_x1 = OW'(i_x[1]);
    assign w_x2 = OW'(i_x[2]);
    assign w_x3 = OW'(i_x[3]);

    assign w_e = w_x0 + w_x2;
    assign w_f = w_x0 - w_x2;
    assign w_g = (w_x1 >>> 1) - w_x3;
    assign w_h = w_x1 + (w_x3 >>> 1);

    assign o_y[0] = w_e + w_h;
    assign o_y[1] = w_f + w_g;
    assign o_y[2] = w_f - w_g;
    assign o_y[3] = w_e - w_h;

endmodule

// File: rtl/tq_idct_dequant_pipe.sv
// Three-stage dequant + 4x4 inverse transform: S1 dequant, S2 row pass,
// S3 column pass with round/clip. One global advance stalls the whole pipe.
module tq_idct_dequant_pipe
    import tq_pkg::*;
#(
    parameter int COEF_W = 15,
    parameter int DQ_W   = 16,
    parameter int RES_W  = 15,
    parameter int TAG_W  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [16*COEF_W-1:0]  coef_i,
    input  logic [5:0]            qp_i,
    input  logic                  dc_ext_i,
    input  logic [DQ_W-1:0]       dc_i,
    input  logic [TAG_W-1:0]      tag_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [16*RES_W-1:0]   res_o,
    output logic [TAG_W-1:0]      tag_o
);
    localparam int S2_W = DQ_W + 3;
    localparam int S3_W = DQ_W + 6;
    localparam int PW   = COEF_W + 14;   // product (5-bit scale) shifted by up to 8
    localparam logic signed [PW-1:0]   DQ_MAX  = PW'(2**(DQ_W-1) - 1);
    localparam logic signed [PW-1:0]   DQ_MIN  = PW'(-(2**(DQ_W-1)));
    localparam logic signed [S3_W:0]   RES_MAX = (S3_W+1)'(2**(RES_W-1) - 1);
    localparam logic signed [S3_W:0]   RES_MIN = (S3_W+1)'(-(2**(RES_W-1)));

    logic                    w_adv;
    logic [3:1]              r_vld;
    logic [TAG_W-1:0]        r_tag1, r_tag2, r_tag3;
    logic signed [DQ_W-1:0]  w_dq  [16];
    logic signed [DQ_W-1:0]  r_s1  [16];
    logic signed [S2_W-1:0]  w_s2  [16];
    logic signed [S2_W-1:0]  r_s2  [16];
    logic signed [S3_W-1:0]  w_s3  [16];
    logic signed [RES_W-1:0] w_res [16];
    logic signed [RES_W-1:0] r_res [16];
    logic [5:0]              w_qp;
    logic [3:0]              w_qdiv;
    logic [2:0]              w_qmod;

    assign w_adv       = !r_vld[3] || out_ready_i;
    assign in_ready_o  = w_adv;
    assign out_valid_o = r_vld[3];
    assign tag_o       = r_tag3;

    assign w_qp   = (qp_i > QP_MAX) ? QP_MAX : qp_i;
    assign w_qdiv = 4'(w_qp / 6'd6);
    assign w_qmod = 3'(w_qp % 6'd6);

    // S1: scale by LevelScale, shift by qp/6, saturate; optional external DC
    for (genvar k = 0; k < 16; k++) begin : g_dq
        logic signed [COEF_W-1:0] w_c;
        logic signed [PW-1:0]     w_prod;
        logic signed [PW-1:0]     w_shf;
        logic signed [DQ_W-1:0]   w_sat;
        assign w_c    = coef_i[k*COEF_W +: COEF_W];
        assign w_prod = PW'(w_c) * PW'($signed({1'b0, level_scale(w_qmod, pos_class(4'(k)))}));
        assign w_shf  = w_prod <<< w_qdiv;
        assign w_sat  = (w_shf > DQ_MAX) ? DQ_W'(DQ_MAX) :
                        (w_shf < DQ_MIN) ? DQ_W'(DQ_MIN) : DQ_W'(w_shf);
        if (k == 0) begin : g_dc
            assign w_dq[k] = dc_ext_i ? $signed(dc_i) : w_sat;
        end else begin : g_ac
            assign w_dq[k] = w_sat;
        end
    end

    // S2: horizontal pass, one butterfly per row
    for (genvar r = 0; r < 4; r++) begin : g_row
        logic signed [DQ_W-1:0] w_x [4];
        logic signed [S2_W-1:0] w_y [4];
        for (genvar c = 0; c < 4; c++) begin : g_el
            assign w_x[c]        = r_s1[4*r+c];
            assign w_s2[4*r+c]   = w_y[c];
        end
        tq_itrans_1d #(.IW(DQ_W), .OW(S2_W)) u_row (.i_x(w_x), .o_y(w_y));
    end

    // S3: vertical pass per column, then round and clip
    for (genvar c = 0; c < 4; c++) begin : g_col
        logic signed [S2_W-1:0] w_x [4];
        logic signed [S3_W-1:0] w_y [4];
        for (genvar r = 0; r < 4; r++) begin : g_el
            assign w_x[r]        = r_s2[4*r+c];
            assign w_s3[4*r+c]   = w_y[r];
        end
        tq_itrans_1d #(.IW(S2_W), .OW(S3_W)) u_col (.i_x(w_x), .o_y(w_y));
    end

    for (genvar k = 0; k < 16; k++) begin : g_rnd
        logic signed [S3_W:0] w_sum;
        logic signed [S3_W:0] w_shr;
        assign w_sum = (S3_W+1)'(w_s3[k]) + (S3_W+1)'(RND_ADD);
        assign w_shr = w_sum >>> RND_SHIFT;
        assign w_res[k] = (w_shr > RES_MAX) ? RES_W'(RES_MAX) :
                          (w_shr < RES_MIN) ? RES_W'(RES_MIN) : RES_W'(w_shr);
        assign res_o[k*RES_W +: RES_W] = r_res[k];
    end

    // Stage registers: all stages move together on advance, hold otherwise
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_vld  <= '0;
            r_tag1 <= '0;
            r_tag2 <= '0;
            r_tag3 <= '0;
            for (int k = 0; k < 16; k++) begin
                r_s1[k]  <= '0;
                r_s2[k]  <= '0;
                r_res[k] <= '0;
            end
        end else if (w_adv) begin
            r_vld  <= {r_vld[2:1], in_valid_i};
            r_tag1 <= tag_i;
            r_tag2 <= r_tag1;
            r_tag3 <= r_tag2;
            for (int k = 0; k < 16; k++) begin
                r_s1[k]  <= w_dq[k];
                r_s2[k]  <= w_s2[k];
                r_res[k] <= w_res[k];
            end
        end
    end

endmodule
